// File: rtl/regfile_dump.sv
// Sequential reader that walks a RegFile read port from lo to hi and
// streams each (address, data) pair out on a valid/ready interface.
module regfile_dump #(
    parameter int addr_width = 1,
    parameter int data_width = 1,
    parameter int lo         = 0,
    parameter int hi         = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    output logic                  BUSY,
    output logic [addr_width-1:0] RD_ADDR,
    input  logic [data_width-1:0] RD_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [addr_width-1:0] OUT_ADDR,
    output logic [data_width-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic                  DONE
);

    // Output handshake: a beat transfers on every edge where OUT_VALID and
    // OUT_READY are both high; while OUT_VALID is high and OUT_READY is low,
    // OUT_ADDR/OUT_DATA/OUT_LAST hold, and OUT_VALID only falls on acceptance,
    // ABORT or RST.

    localparam logic [addr_width-1:0] lo_a = addr_width'(lo);
    localparam logic [addr_width-1:0] hi_a = addr_width'(hi);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [addr_width-1:0] cursor, cursor_n;
    logic [addr_width-1:0] addr_q, addr_n;
    logic [data_width-1:0] data_q, data_n;
    logic                  valid_q, valid_n;
    logic                  last_q, last_n;
    logic                  done_q, done_n;
    logic                  load;
    logic                  at_hi;

    assign at_hi = (cursor == hi_a);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cursor  <= lo_a;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cursor  <= cursor_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            last_q  <= last_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        addr_n   = addr_q;
        data_n   = data_q;
        valid_n  = valid_q;
        last_n   = last_q;
        done_n   = 1'b0;
        load     = !valid_q || OUT_READY;

        if (ABORT) begin
            // ABORT in IDLE is a no-op but still masks a coincident START.
            if (state != IDLE) begin
                state_n  = IDLE;
                valid_n  = 1'b0;
                last_n   = 1'b0;
                cursor_n = lo_a;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        cursor_n = lo_a;
                        state_n  = RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        data_n  = RD_DATA;
                        addr_n  = cursor;
                        last_n  = at_hi;
                        valid_n = 1'b1;
                        if (at_hi) begin
                            state_n = DRAIN;
                        end else begin
                            cursor_n = cursor + addr_width'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (OUT_READY) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign BUSY      = (state != IDLE);
    assign RD_ADDR   = cursor;
    assign OUT_VALID = valid_q;
    assign OUT_ADDR  = addr_q;
    assign OUT_DATA  = data_q;
    assign OUT_LAST  = last_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: a 4x8 register file model feeds two
// instances (lo=0/hi=3 and lo=hi=2); accepted beats are scored against a queue.
module tb_regfile_dump;

    localparam int W = 11;  // {last, addr[1:0], data[7:0]}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start2, abort, out_ready, sel;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [7:0] mem [4];

    always @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    logic       busy1, valid1, last1, done1;
    logic [1:0] rd_addr1, addr1;
    logic [7:0] rd_data1, data1;
    logic       busy2, valid2, last2, done2;
    logic [1:0] rd_addr2, addr2;
    logic [7:0] rd_data2, data2;

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

    regfile_dump #(.addr_width(2), .data_width(8), .lo(0), .hi(3)) dut (
        .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .BUSY(busy1),
        .RD_ADDR(rd_addr1), .RD_DATA(rd_data1), .OUT_VALID(valid1),
        .OUT_READY(out_ready), .OUT_ADDR(addr1), .OUT_DATA(data1),
        .OUT_LAST(last1), .DONE(done1)
    );

    regfile_dump #(.addr_width(2), .data_width(8), .lo(2), .hi(2)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .ABORT(abort), .BUSY(busy2),
        .RD_ADDR(rd_addr2), .RD_DATA(rd_data2), .OUT_VALID(valid2),
        .OUT_READY(out_ready), .OUT_ADDR(addr2), .OUT_DATA(data2),
        .OUT_LAST(last2), .DONE(done2)
    );

    logic       o_valid, o_last, o_done;
    logic [1:0] o_addr;
    logic [7:0] o_data;
    assign o_valid = sel ? valid2 : valid1;
    assign o_last  = sel ? last2  : last1;
    assign o_done  = sel ? done2  : done1;
    assign o_addr  = sel ? addr2  : addr1;
    assign o_data  = sel ? data2  : data1;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic l, input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back({l, a, d});
    endtask

    // One clock: score a beat that will be accepted at this edge, advance,
    // then check hold-while-stalled and DONE/OUT_VALID exclusivity.
    task automatic cycle();
        logic         stalled, guard;
        logic [W-1:0] held;
        logic [W:0]   e;
        if (o_valid && out_ready) begin
            if (exp_q.size() > 0) e = {1'b1, exp_q.pop_front()};
            else e = '0;
            chk("beat", 32'({1'b1, o_last, o_addr, o_data}), 32'(e));
        end
        stalled = o_valid && !out_ready;
        guard   = rst || abort;
        held    = {o_last, o_addr, o_data};
        @(posedge clk);
        #1;
        if (o_done) done_cnt++;
        chk("done_vs_valid", 32'(o_done & o_valid), 32'(0));
        if (stalled && !guard)
            chk("hold", 32'({o_valid, o_last, o_addr, o_data}), 32'({1'b1, held}));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic chk_reset1(input string tag);
        chk(tag, 32'({busy1, valid1, addr1, data1, last1, done1, rd_addr1}), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; abort = 1'b0;
        out_ready = 1'b0; sel = 1'b0; we = 1'b0; wa = '0; wd = '0;

        // Load 11,22,33,44 while held in reset
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wa = 2'(i); wd = 8'((i + 1) * 8'h11);
            cycle();
        end
        we = 1'b0;
        cycle();
        chk_reset1("reset1");
        chk("reset2", 32'({busy2, valid2, addr2, data2, last2, done2}), 32'(0));
        chk("reset2_rd_addr", 32'(rd_addr2), 32'(2));
        rst = 1'b0;

        // Full-rate dump
        done_cnt = 0;
        push(1'b0, 2'd0, 8'h11); push(1'b0, 2'd1, 8'h22);
        push(1'b0, 2'd2, 8'h33); push(1'b1, 2'd3, 8'h44);
        out_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t1_latency_run", 32'({busy1, valid1}), 32'(2'b10));
        cycle();
        for (int k = 0; k < 4; k++) begin
            chk("t1_stream_valid", 32'(valid1), 32'(1));
            cycle();
        end
        chk("t1_done", 32'({done1, valid1, busy1}), 32'(3'b100));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        cycle();
        chk("t1_done_pulse", 32'(done_cnt), 32'(1));

        // Back-pressure 1,0,0,1,...
        done_cnt = 0;
        push(1'b0, 2'd0, 8'h11); push(1'b0, 2'd1, 8'h22);
        push(1'b0, 2'd2, 8'h33); push(1'b1, 2'd3, 8'h44);
        out_ready = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            out_ready = (i % 3 == 0);
            cycle();
        end
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        out_ready = 1'b0;
        cycle();
        chk("t2_done_pulse", 32'(done_cnt), 32'(1));
        chk("t2_idle", 32'({busy1, valid1}), 32'(0));

        // Coherence: same-edge write to addr 0 invisible, later write to addr 2 visible
        done_cnt = 0;
        push(1'b0, 2'd0, 8'h11); push(1'b0, 2'd1, 8'h22);
        push(1'b0, 2'd2, 8'h99); push(1'b1, 2'd3, 8'h44);
        out_ready = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        we = 1'b1; wa = 2'd0; wd = 8'h55;
        cycle();
        we = 1'b0;
        chk("t3_rd_addr", 32'(rd_addr1), 32'(1));
        we = 1'b1; wa = 2'd2; wd = 8'h99;
        cycle();
        we = 1'b0;
        cycle();
        out_ready = 1'b1;
        drain(40);
        cycle();
        chk("t3_done_pulse", 32'(done_cnt), 32'(1));

        // ABORT with beat 1 pending; contents now 55,22,99,44
        done_cnt = 0;
        push(1'b0, 2'd0, 8'h55);
        out_ready = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("t4_beat1_pending", 32'({valid1, addr1}), 32'(3'b101));
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("t4_abort", 32'({valid1, busy1, last1, done1, rd_addr1}), 32'(0));
        cycle();
        chk("t4_no_done", 32'(done_cnt), 32'(0));
        start = 1'b1; abort = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        chk("t4_abort_masks_start", 32'(busy1), 32'(0));
        push(1'b0, 2'd0, 8'h55); push(1'b0, 2'd1, 8'h22);
        push(1'b0, 2'd2, 8'h99); push(1'b1, 2'd3, 8'h44);
        out_ready = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        drain(40);
        cycle();
        chk("t4_restart_done", 32'(done_cnt), 32'(1));

        // RST mid-dump
        out_ready = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("t6_valid_before_rst", 32'(valid1), 32'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset1("t6_reset_mid_dump");
        cycle();
        chk("t6_stays_idle", 32'({busy1, valid1}), 32'(0));

        // Single-address dump lo=hi=2, START held through BUSY
        we = 1'b1; wa = 2'd2; wd = 8'h33;
        cycle();
        we = 1'b0;
        sel = 1'b1; done_cnt = 0;
        push(1'b1, 2'd2, 8'h33);
        out_ready = 1'b1; start2 = 1'b1;
        cycle();
        chk("t5_run", 32'({busy2, valid2}), 32'(2'b10));
        cycle();
        chk("t5_single_beat", 32'({valid2, last2, addr2}), 32'(4'b1110));
        cycle();
        start2 = 1'b0;
        chk("t5_done", 32'({done2, busy2, valid2}), 32'(3'b100));
        cycle();
        chk("t5_no_restart", 32'({busy2, valid2, done2}), 32'(0));
        chk("t5_done_pulse", 32'(done_cnt), 32'(1));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
